pixel_window_gen: RTL

- Upstream feeder for the radar image window consumer.
- Accepts a raster stream of two adjacent pixels per beat (even column, odd column).
- Buffers the previous 4 image rows in line RAMs and emits a 5-row vertical tap column for each pixel of the pair.
- Tags every output beat with the centre row/column indices, channel number and frame markers.

---
 rtl/pixwin_pkg.sv | 27 ++
 rtl/pixel_window_gen_if.sv | 39 +++
 rtl/line_buf_ram.sv | 39 +++
 rtl/pixel_window_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pixwin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixwin_pkg
// Description : Shared types and constants for the pixel window generator.
// Revision    : 1.0
// ============================================================================
package pixwin_pkg;

  localparam int IDX_W  = 11;
  localparam int TAPS   = 5;
  localparam int LANES  = 2;
  localparam int CH_W   = 4;
  localparam int LB_NUM = TAPS - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Tap t (0 = oldest row) comes from line buffer LB(LB_NUM-1-t).
  function automatic int tap_lb(input int t);
    return LB_NUM - 1 - t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pixel_window_gen_if
// Description : Pixel-pair input stream and tagged tap-window output bundle.
// Revision    : 1.0
// ============================================================================
interface pixel_window_gen_if #(
  parameter int DATA_WIDTH = 16
);
  import pixwin_pkg::*;

  logic [2*DATA_WIDTH-1:0]               in_pixel;
  logic                                  in_valid;
  logic                                  in_sof;
  logic [CH_W-1:0]                       in_channel;
  logic [IDX_W-1:0]                      row_idx1;
  logic [IDX_W-1:0]                      col_idx1;
  logic [IDX_W-1:0]                      row_idx2;
  logic [IDX_W-1:0]                      col_idx2;
  logic [CH_W-1:0]                       channel_num;
  logic                                  data_start;
  logic                                  data_end;
  logic                                  data_vaild;
  logic [DATA_WIDTH*TAPS*LANES-1:0]      pixel_out;

  modport slave (
    input  in_pixel, in_valid, in_sof, in_channel,
    output row_idx1, col_idx1, row_idx2, col_idx2, channel_num,
           data_start, data_end, data_vaild, pixel_out
  );

  modport master (
    output in_pixel, in_valid, in_sof, in_channel,
    input  row_idx1, col_idx1, row_idx2, col_idx2, channel_num,
           data_start, data_end, data_vaild, pixel_out
  );

endinterface
`default_nettype wire

// File: rtl/line_buf_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_buf_ram
// Description : Simple dual-port line RAM with one-cycle registered read.
// Revision    : 1.0
// ============================================================================
module line_buf_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  // Read returns the contents before a same-edge write (read-first).
  always_comb begin
    rd_d = rd_q;
    if (rd_en) rd_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule
`default_nettype wire

// File: rtl/pixel_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : pixel_window_gen
// Description : Buffers 4 rows and emits a 5-row tap column per pixel pair.
// Revision    : 1.0
// ============================================================================
module pixel_window_gen
  import pixwin_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                clk,
  input  logic                rst,
  pixel_window_gen_if.slave   bus
);

  localparam int DEPTH = IMG_WIDTH / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW    = LANES * DATA_WIDTH;
  localparam int OW    = DATA_WIDTH * TAPS * LANES;
  localparam logic [AW-1:0]    LAST_PAIR     = AW'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_ROW      = IDX_W'(IMG_HEIGHT - 1);
  localparam logic [IDX_W-1:0] LAST_FILL_ROW = IDX_W'(LB_NUM - 1);
  localparam logic [IDX_W-1:0] FIRST_OUT_ROW = IDX_W'(LB_NUM);

  state_e            state_q, state_d;
  logic [AW-1:0]     pair_q, pair_d;
  logic [IDX_W-1:0]  row_q, row_d;
  logic [CH_W-1:0]   ch_q, ch_d;

  logic              sof_beat, accept, wrap;
  logic [AW-1:0]     eff_pair;
  logic [IDX_W-1:0]  eff_row;

  logic              s1_vld_q, s1_vld_d;
  logic              s1_emit_q, s1_emit_d;
  logic              s1_fwd_q, s1_fwd_d;
  logic [AW-1:0]     s1_addr_q, s1_addr_d;
  logic [IDX_W-1:0]  s1_row_q, s1_row_d;
  logic [PW-1:0]     s1_pix_q, s1_pix_d;

  logic [PW-1:0]     rd_data   [LB_NUM];
  logic [PW-1:0]     wr_data   [LB_NUM];
  logic [PW-1:0]     eff_tap   [LB_NUM];
  logic [PW-1:0]     wr_last_q [LB_NUM];
  logic [PW-1:0]     wr_last_d [LB_NUM];

  logic              vld_q, vld_d, start_q, start_d, end_q, end_d;
  logic [IDX_W-1:0]  orow_q, orow_d, ocol1_q, ocol1_d, ocol2_q, ocol2_d;
  logic [OW-1:0]     pix_q, pix_d;

  // A sof beat is always taken as row 0, pair 0 regardless of the counters.
  always_comb begin
    sof_beat = bus.in_valid & bus.in_sof;
    accept   = bus.in_valid & ((state_q != IDLE) | bus.in_sof);
    eff_pair = sof_beat ? '0 : pair_q;
    eff_row  = sof_beat ? '0 : row_q;
    wrap     = (eff_pair == LAST_PAIR);
  end

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    row_d   = row_q;
    ch_d    = ch_q;
    if (sof_beat) begin
      state_d = FILL;
      ch_d    = bus.in_channel;
    end
    if (accept) begin
      if (wrap) begin
        pair_d = '0;
        row_d  = eff_row + 1'b1;
        if (eff_row == LAST_FILL_ROW) begin
          state_d = STREAM;
        end else if (eff_row == LAST_ROW) begin
          state_d = IDLE;
          row_d   = '0;
        end
      end else begin
        pair_d = eff_pair + 1'b1;
        row_d  = eff_row;
      end
    end
  end

  // Stage 1 lines up the beat with its RAM read data. The forward flag covers
  // a read that collides with the shift write-back to the same address.
  always_comb begin
    s1_vld_d  = accept;
    s1_emit_d = accept && (eff_row >= FIRST_OUT_ROW);
    s1_fwd_d  = accept && s1_vld_q && (s1_addr_q == eff_pair);
    s1_addr_d = accept ? eff_pair : s1_addr_q;
    s1_row_d  = accept ? eff_row : s1_row_q;
    s1_pix_d  = accept ? bus.in_pixel : s1_pix_q;
  end

  for (genvar k = 0; k < LB_NUM; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign wr_data[k] = s1_pix_q;
    end else begin : g_chain
      assign wr_data[k] = eff_tap[k-1];
    end
    assign eff_tap[k]   = s1_fwd_q ? wr_last_q[k] : rd_data[k];
    assign wr_last_d[k] = s1_vld_q ? wr_data[k] : wr_last_q[k];

    line_buf_ram #(
      .WIDTH (PW),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_ram (
      .clk     (clk),
      .wr_en   (s1_vld_q),
      .wr_addr (s1_addr_q),
      .wr_data (wr_data[k]),
      .rd_en   (accept),
      .rd_addr (eff_pair),
      .rd_data (rd_data[k])
    );
  end

  always_comb begin
    vld_d   = s1_emit_q;
    start_d = s1_emit_q && (s1_row_q == FIRST_OUT_ROW) && (s1_addr_q == '0);
    end_d   = s1_emit_q && (s1_row_q == LAST_ROW) && (s1_addr_q == LAST_PAIR);
    orow_d  = orow_q;
    ocol1_d = ocol1_q;
    ocol2_d = ocol2_q;
    pix_d   = pix_q;
    if (s1_emit_q) begin
      orow_d  = s1_row_q - IDX_W'(2);
      ocol1_d = IDX_W'({s1_addr_q, 1'b0});
      ocol2_d = IDX_W'({s1_addr_q, 1'b1});
      for (int k = 0; k < LANES; k++) begin
        for (int t = 0; t < LB_NUM; t++) begin
          pix_d[(k*TAPS+t)*DATA_WIDTH +: DATA_WIDTH] =
            eff_tap[tap_lb(t)][k*DATA_WIDTH +: DATA_WIDTH];
        end
        pix_d[(k*TAPS+LB_NUM)*DATA_WIDTH +: DATA_WIDTH] =
          s1_pix_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      row_q     <= '0;
      ch_q      <= '0;
      s1_vld_q  <= 1'b0;
      s1_emit_q <= 1'b0;
      s1_fwd_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_row_q  <= '0;
      s1_pix_q  <= '0;
      vld_q     <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      orow_q    <= '0;
      ocol1_q   <= '0;
      ocol2_q   <= '0;
      pix_q     <= '0;
      for (int k = 0; k < LB_NUM; k++) wr_last_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      row_q     <= row_d;
      ch_q      <= ch_d;
      s1_vld_q  <= s1_vld_d;
      s1_emit_q <= s1_emit_d;
      s1_fwd_q  <= s1_fwd_d;
      s1_addr_q <= s1_addr_d;
      s1_row_q  <= s1_row_d;
      s1_pix_q  <= s1_pix_d;
      vld_q     <= vld_d;
      start_q   <= start_d;
      end_q     <= end_d;
      orow_q    <= orow_d;
      ocol1_q   <= ocol1_d;
      ocol2_q   <= ocol2_d;
      pix_q     <= pix_d;
      for (int k = 0; k < LB_NUM; k++) wr_last_q[k] <= wr_last_d[k];
    end
  end

  assign bus.row_idx1    = orow_q;
  assign bus.row_idx2    = orow_q;
  assign bus.col_idx1    = ocol1_q;
  assign bus.col_idx2    = ocol2_q;
  assign bus.channel_num = ch_q;
  assign bus.data_start  = start_q;
  assign bus.data_end    = end_q;
  assign bus.data_vaild  = vld_q;
  assign bus.pixel_out   = pix_q;

endmodule
`default_nettype wire
